// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// live fill count, sticky overflow/underflow flags and selectable FWFT output.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic [ADDR_WIDTH:0]   almost_full_thresh,
    input  logic [ADDR_WIDTH:0]   almost_empty_thresh,
    input  logic                  err_clear,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE     = (ADDR_WIDTH)'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_COUNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_prog: FIFO_DEPTH must be a power of 2 and >= 2");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("sync_fifo_prog: FWFT must be 0 or 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   fill_count_reg, fill_count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags decode the registered count; thresholds are compared live.
    assign fifo_full         = (fill_count_reg == DEPTH_COUNT);
    assign fifo_empty        = (fill_count_reg == '0);
    assign fifo_almost_full  = (fill_count_reg >= almost_full_thresh);
    assign fifo_almost_empty = (fill_count_reg <= almost_empty_thresh);
    assign fill_count        = fill_count_reg;
    assign overflow          = overflow_reg;
    assign underflow         = underflow_reg;

    assign wr_accept = wr_en && !fifo_full;
    assign rd_accept = rd_en && !fifo_empty;

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        fill_count_next = fill_count_reg;
        overflow_next   = overflow_reg;
        underflow_next  = underflow_reg;

        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (wr_accept && !rd_accept) begin
            fill_count_next = fill_count_reg + COUNT_ONE;
        end else if (rd_accept && !wr_accept) begin
            fill_count_next = fill_count_reg - COUNT_ONE;
        end

        // A fresh error in the clearing cycle wins over err_clear.
        if (err_clear) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (wr_en && fifo_full) begin
            overflow_next = 1'b1;
        end
        if (rd_en && fifo_empty) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fill_count_reg <= '0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            fill_count_reg <= fill_count_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered_read
            logic [DATA_WIDTH-1:0] data_out_reg;
            logic                  data_valid_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_out_reg   <= '0;
                    data_valid_reg <= 1'b0;
                end else begin
                    data_valid_reg <= rd_accept;
                    if (rd_accept) begin
                        data_out_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign data_out   = data_out_reg;
            assign data_valid = data_valid_reg;
        end else begin : g_fall_through
            // Head word is shown directly; rd_en acknowledges and pops it.
            assign data_out   = fifo_empty ? '0 : mem[rd_ptr_reg];
            assign data_valid = !fifo_empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomised and directed scoreboard bench for sync_fifo_prog; a registered-read
// and an FWFT instance share the same stimulus and a queue-based reference model.
module tb_sync_fifo_prog;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic          err_clear;
    logic [DW-1:0] data_in;
    logic [AW:0]   af;
    logic [AW:0]   ae;

    logic [DW-1:0] d0_data_out, d1_data_out;
    logic          d0_valid, d1_valid;
    logic [AW:0]   d0_fill, d1_fill;
    logic          d0_full, d1_full, d0_empty, d1_empty;
    logic          d0_afull, d1_afull, d0_aempty, d1_aempty;
    logic          d0_over, d1_over, d0_under, d1_under;

    sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_dut_reg (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d0_data_out), .data_valid(d0_valid),
        .almost_full_thresh(af), .almost_empty_thresh(ae), .err_clear(err_clear),
        .fill_count(d0_fill), .fifo_full(d0_full), .fifo_empty(d0_empty),
        .fifo_almost_full(d0_afull), .fifo_almost_empty(d0_aempty),
        .overflow(d0_over), .underflow(d0_under)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_dut_fwft (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d1_data_out), .data_valid(d1_valid),
        .almost_full_thresh(af), .almost_empty_thresh(ae), .err_clear(err_clear),
        .fill_count(d1_fill), .fifo_full(d1_full), .fifo_empty(d1_empty),
        .fifo_almost_full(d1_afull), .fifo_almost_empty(d1_aempty),
        .overflow(d1_over), .underflow(d1_under)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: stored words, expected read-data stream, error flags.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_over;
    bit            m_under;
    bit            m_valid;
    logic [DW-1:0] m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        n = model_q.size();
        chk("d0_fill",     d0_fill,   n);
        chk("d0_full",     d0_full,   n == DEPTH);
        chk("d0_empty",    d0_empty,  n == 0);
        chk("d0_afull",    d0_afull,  n >= int'(af));
        chk("d0_aempty",   d0_aempty, n <= int'(ae));
        chk("d0_overflow", d0_over,   m_over);
        chk("d0_underflow",d0_under,  m_under);
        chk("d0_data_out", d0_data_out, m_last);
        chk("d0_valid",    d0_valid,  m_valid);
        chk("d1_fill",     d1_fill,   n);
        chk("d1_full",     d1_full,   n == DEPTH);
        chk("d1_empty",    d1_empty,  n == 0);
        chk("d1_afull",    d1_afull,  n >= int'(af));
        chk("d1_aempty",   d1_aempty, n <= int'(ae));
        chk("d1_overflow", d1_over,   m_over);
        chk("d1_underflow",d1_under,  m_under);
    endtask

    // One clock of stimulus; the model is advanced at the edge the DUT uses.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit ec);
        bit wacc;
        bit racc;
        wr_en     = w;
        rd_en     = r;
        data_in   = d;
        err_clear = ec;
        @(posedge clk);
        wacc = w && (model_q.size() < DEPTH);
        racc = r && (model_q.size() > 0);
        if (ec) begin
            m_over  = 1'b0;
            m_under = 1'b0;
        end
        if (w && !wacc) m_over = 1'b1;
        if (r && !racc) m_under = 1'b1;
        m_valid = racc;
        if (racc) begin
            m_last = model_q.pop_front();
            exp_q.push_back(m_last);
        end
        if (wacc) model_q.push_back(d);
        #1;
        check_status();
    endtask

    task automatic do_reset();
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        err_clear = 1'b0;
        data_in   = '0;
        reset     = 1'b1;
        model_q.delete();
        exp_q.delete();
        m_over  = 1'b0;
        m_under = 1'b0;
        m_valid = 1'b0;
        m_last  = '0;
        #1;
        check_status();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_status();
    endtask

    // Output monitor: pops expected read data on each registered-read pulse
    // and checks the fall-through head against the model every cycle.
    always @(negedge clk) begin
        if (d0_valid) begin
            if (exp_q.size() == 0) chk("d0_valid_without_read", d0_valid, 1'b0);
            else chk("d0_read_data", d0_data_out, exp_q.pop_front());
        end
        if (model_q.size() > 0) begin
            chk("d1_head_data", d1_data_out, model_q[0]);
            chk("d1_valid", d1_valid, 1'b1);
        end else begin
            chk("d1_empty_data", d1_data_out, '0);
            chk("d1_valid", d1_valid, 1'b0);
        end
    end

    initial begin
        int pw;
        reset     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        err_clear = 1'b0;
        data_in   = '0;
        af        = 5'd12;
        ae        = 5'd3;
        #2;

        // Reset state and fill/overflow/drain in order.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
        step(1'b1, 1'b0, 32'hDEAD, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Steady fill of 8 with simultaneous read/write across pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h100 + DW'(i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h200 + DW'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);

        // Threshold boundaries, including a live threshold change.
        do_reset();
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 32'h300 + DW'(i), 1'b0);
        af = 5'd10;
        #1;
        check_status();
        af = 5'd12;
        step(1'b1, 1'b0, 32'h3FF, 1'b0);
        af = 5'd20;
        ae = 5'd17;
        step(1'b1, 1'b1, 32'h400, 1'b0);
        af = 5'd12;
        ae = 5'd3;

        // Underflow, clearing, and clear colliding with a new error.
        do_reset();
        step(1'b1, 1'b0, 32'h1234, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b1, 1'b1, 32'h55, 1'b0);

        // Fall-through write into empty, pop, then reset with words held.
        do_reset();
        step(1'b1, 1'b0, 32'hA5, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h500 + DW'(i), 1'b0);
        do_reset();

        // Randomised phases with varying write/read bias.
        pw = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) pw = $urandom_range(10, 90);
            if ($urandom_range(0, 49) == 0) begin
                af = AW'($urandom_range(0, 31));
                ae = AW'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) >= pw,
                     $urandom, $urandom_range(0, 19) == 0);
            end
        end

        wr_en = 1'b0;
        rd_en = 1'b0;
        err_clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("unseen_read_pulses", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
